// File: rtl/vector_sync_filter_if.sv
// rtl/vector_sync_filter_if.sv - vector bundle between an async source and the sync filter
interface vector_sync_filter_if #(
  parameter int pWIDTH = 18
);
  logic [pWIDTH-1:0] ivector;
  logic [pWIDTH-1:0] ovector;
  logic              ochange;
  logic [pWIDTH-1:0] ochange_mask;

  modport master (
    output ivector,
    input  ovector,
    input  ochange,
    input  ochange_mask
  );

  modport slave (
    input  ivector,
    output ovector,
    output ochange,
    output ochange_mask
  );
endinterface

// File: rtl/vector_sync_filter.sv
// rtl/vector_sync_filter.sv - multi-stage vector synchroniser with per-bit or coherent deglitch filter
module vector_sync_filter #(
  parameter int                pWIDTH     = 18,
  parameter int                pREG_DEPTH = 3,
  parameter int                pFILTER    = 4,
  parameter int                pCOHERENT  = 0,
  parameter logic [pWIDTH-1:0] pRESET_VAL = '0
) (
  input  logic                 clock,
  input  logic                 rst_n,
  vector_sync_filter_if.slave  vbus
);

  localparam int             CW       = (pFILTER > 1) ? $clog2(pFILTER) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(pFILTER - 1);

  logic [pWIDTH-1:0] chain [pREG_DEPTH];
  logic [pWIDTH-1:0] s;
  logic [pWIDTH-1:0] cand;
  logic [pWIDTH-1:0] ovector;
  logic [pWIDTH-1:0] next_ov;
  logic [pWIDTH-1:0] commit;
  logic              ochange;
  logic [pWIDTH-1:0] ochange_mask;

  // chain[0] is the only stage allowed to go metastable
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < pREG_DEPTH; i++) chain[i] <= pRESET_VAL;
      cand <= pRESET_VAL;
    end else begin
      chain[0] <= vbus.ivector;
      for (int i = 1; i < pREG_DEPTH; i++) chain[i] <= chain[i-1];
      cand <= s;
    end
  end

  assign s = chain[pREG_DEPTH-1];

  generate
    if (pCOHERENT != 0) begin : g_coh
      logic [CW-1:0] cnt;
      logic          hit;

      assign hit    = (s == cand) && (cand != ovector) && (cnt == CNT_LAST);
      assign commit = {pWIDTH{hit}};

      // any movement on any bit restarts the shared count, absorbing bus skew
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
          cnt <= '0;
        else if ((s != cand) || (cand == ovector) || hit)
          cnt <= '0;
        else
          cnt <= cnt + CW'(1);
      end
    end else begin : g_bit
      for (genvar i = 0; i < pWIDTH; i++) begin : g_unit
        logic [CW-1:0] cnt;
        logic          hit;

        assign hit       = (s[i] == cand[i]) && (cand[i] != ovector[i]) && (cnt == CNT_LAST);
        assign commit[i] = hit;

        always_ff @(posedge clock or negedge rst_n) begin
          if (!rst_n)
            cnt <= '0;
          else if ((s[i] != cand[i]) || (cand[i] == ovector[i]) || hit)
            cnt <= '0;
          else
            cnt <= cnt + CW'(1);
        end
      end
    end
  endgenerate

  assign next_ov = (ovector & ~commit) | (cand & commit);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ovector      <= pRESET_VAL;
      ochange      <= 1'b0;
      ochange_mask <= '0;
    end else begin
      ovector      <= next_ov;
      ochange      <= |commit;
      ochange_mask <= ovector ^ next_ov;
    end
  end

  assign vbus.ovector      = ovector;
  assign vbus.ochange      = ochange;
  assign vbus.ochange_mask = ochange_mask;

endmodule

// File: doc/vector_sync_filter.md
# vector_sync_filter

Parametrised successor to the team's multi-stage vector synchroniser. It brings an asynchronous status or control vector into the `clock` domain through a `pREG_DEPTH` flop chain, then applies a stability (deglitch) filter, either per bit or across the whole vector. It reports each committed update with a one-cycle strobe and a mask of the changed bits. It sits on the receiving side of slow status buses (PHY status pins, link/strap bits, counters read from foreign domains) feeding the Ethernet core.

## Interface
Parameters:
- `pWIDTH`, 18: vector width, ≥1.
- `pREG_DEPTH`, 3: synchroniser stages, ≥2.
- `pFILTER`, 4: stability count, ≥1. An update commits after the synchronised value has been unchanged for `pFILTER+1` consecutive cycles.
- `pCOHERENT`, 0: filter mode.
  - 0: per-bit filters.
  - 1: one whole-vector filter, for multi-bit values that must never be seen half-updated.
- `pRESET_VAL`, '0: reset value of all vector-wide registers.

Ports:
- `clock`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ivector`, in, `pWIDTH`: asynchronous input vector.
- `ovector`, out, `pWIDTH`: filtered, committed vector (registered).
- `ochange`, out, 1: one-cycle pulse in the cycle `ovector` takes a new value.
- `ochange_mask`, out, `pWIDTH`: bits of `ovector` that changed in the `ochange` cycle. It is zero in all other cycles.

## Operation
- Sync chain: `chain[1..pREG_DEPTH]` registers `ivector` on `clock`. Call the last stage `s`. No combinational logic sits between stages.
- Candidate register: `cand <= s` every cycle.
- Filter counter of width `$clog2(pFILTER)` (minimum 1 bit). There is one counter per bit when `pCOHERENT=0`, and one shared counter over the full vector when `pCOHERENT=1`. Each cycle, for each filter unit (a bit, or the whole vector):
  - `s != cand`: counter is set to 0 (input is still moving).
  - else `cand == ovector`: counter is set to 0 (nothing pending).
  - else `cnt == pFILTER-1`: commit, so `ovector <= cand` and the counter is set to 0.
  - else: counter increments.
- Coherent mode: every bit of `ovector` updates in the same cycle. A change on any bit of `s` restarts the shared counter.
- Per-bit mode: bits commit independently. Several bits may commit in the same cycle.
- `ochange` is registered and equals the OR of the commit conditions. `ochange_mask` equals `old ovector ^ new ovector`, registered alongside `ovector`.
- Glitch handling:
  - If `s` returns to the committed value before the commit, the counter clears and no output event occurs.
  - If `s` moves to a third value, the counter restarts toward that value.
- No state machine beyond the counters. There is no handshake and no backpressure: the block is free-running.

## Timing
- Reset (asynchronous assert, synchronous use after deassert) sets:
  - `chain`, `cand`, `ovector` to `pRESET_VAL`;
  - counters to 0;
  - `ochange` to 0 and `ochange_mask` to 0.
- The first commit is possible no earlier than `pREG_DEPTH+pFILTER+1` edges after `rst_n` deasserts.
- Latency: take `ivector` as stable before rising edge 1 and held. Then:
  - `s` is new after edge `pREG_DEPTH`;
  - `cand` is new after edge `pREG_DEPTH+1`;
  - `ovector` and `ochange` update after edge `pREG_DEPTH+pFILTER+1`.
  - Default parameters give 8 edges.
- Rejection: a level on `s` lasting ≤`pFILTER` cycles never reaches `ovector`. A level lasting ≥`pFILTER+1` cycles always does.
- The minimum spacing between two commits of the same filter unit is `pFILTER+1` cycles.
- Reset asserted mid-count: everything returns to reset values immediately, with no partial commit and no `ochange`.
- Metastability is confined to `chain[1]`. In coherent mode, bus skew across bits is absorbed because any skewed arrival restarts the shared counter.

## Test plan
- Reset: `pRESET_VAL=18'h2A5A5`, hold `rst_n=0` with toggling input. Then `ovector=18'h2A5A5`, `ochange=0`, `ochange_mask=0`; after deassert with `ivector=18'h2A5A5`, no `ochange` ever.
- Latency, defaults: step `ivector` from 0 to `18'h00F0F` and hold. `ovector=18'h00F0F`, `ochange=1` and `ochange_mask=18'h00F0F` after edge 8, for exactly one cycle.
- Glitch rejection, `pFILTER=4`: pulse bit 3 high for 4 cycles then low gives no change. A 5-cycle pulse gives exactly one rise event on bit 3 (mask `18'h8`), later followed by a fall event.
- Per-bit mode: bit 0 steps at cycle 0 and bit 1 steps at cycle 2. This gives two separate `ochange` pulses, 2 cycles apart, with masks `18'h1` then `18'h2`.
- Coherent mode: bits 0..7 arrive skewed over 3 cycles (`8'h00` to `8'hFF`). Exactly one `ochange` occurs with mask `18'h000FF`, and `ovector` never shows an intermediate value.
- Reset mid-count: assert `rst_n=0` while the counter is at 2 of 3. The outputs return to reset values instantly, and no `ochange` pulse occurs before or after the reset.
